// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for a 5-stage in-order pipeline.
// Resolves load-use hazards, taken-branch flushes and data-memory wait states.
// Control outputs are Mealy (combinational from state and inputs). Priority,
// highest first: error, memory stall, branch, load-use.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall_cycles / flush_events counters. Without it both ports are tied to 0.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   id_rs1, id_rs2         source registers of the instruction in ID
//   ex_rd, ex_memread      destination and load flag of the instruction in EX
//   ex_branch_taken        taken branch resolved in EX
//   mem_req, dmem_ready    MEM-stage access request, data memory completion
//   pc_write, ifid_write   PC and IF/ID register enables
//   pipe_hold              hold of ID/EX, EX/MEM and MEM/WB
//   ifid_flush, idex_flush bubble insertion into IF/ID and ID/EX
//   mem_err                sticky data-memory timeout
//   stall_cycles           count of cycles with pc_write low
//   flush_events           count of cycles with ifid_flush high
module pipe_hazard_ctrl #(
   parameter int unsigned WAIT_MAX = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_memread,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic        dmem_ready,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        pipe_hold,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        mem_err,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_events
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic               branch_pend, branch_pend_nxt;
   logic               lu, ms;

   // Hazard conditions
   assign lu = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   assign ms = mem_req & ~dmem_ready;

   // State, wait counter and pending-branch registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         branch_pend <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         branch_pend <= branch_pend_nxt;
      end
   end

   // Next state and Mealy control outputs
   always_comb begin
      state_nxt       = state;
      wait_cnt_nxt    = wait_cnt;
      branch_pend_nxt = branch_pend;
      pc_write        = 1'b1;
      ifid_write      = 1'b1;
      pipe_hold       = 1'b0;
      ifid_flush      = 1'b0;
      idex_flush      = 1'b0;
      mem_err         = 1'b0;
      case (state)
         ST_ERR: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            mem_err    = 1'b1;
         end
         default: begin
            if (ms) begin
               pc_write        = 1'b0;
               ifid_write      = 1'b0;
               pipe_hold       = 1'b1;
               // A branch resolved while frozen is remembered and flushed on release
               branch_pend_nxt = branch_pend | ex_branch_taken;
               if (state == ST_RUN) begin
                  // First stalled cycle already counts as wait cycle 1
                  state_nxt    = ST_WAIT;
                  wait_cnt_nxt = CNT_W'(1);
               end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                  state_nxt    = ST_ERR;
               end else begin
                  wait_cnt_nxt = wait_cnt + CNT_W'(1);
               end
            end else begin
               // Ready (or request gone) wins over a timeout in the same cycle
               state_nxt       = ST_RUN;
               wait_cnt_nxt    = '0;
               branch_pend_nxt = 1'b0;
               if (ex_branch_taken | branch_pend) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (lu) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
               end
            end
         end
      endcase
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_write && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
         if (ifid_flush && (flush_events != 16'hFFFF))
            flush_events <= flush_events + 16'd1;
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule
